// File: rtl/vecmac_acc.sv
// Lane-wise multiply, lane sum and multi-beat accumulate, with optional saturation.
// Latency: last beat accepted at edge t gives out_valid after edge t+3 (S1, S2, S3, output reg).
// Backpressure: in_ready = !(out_valid && !out_ready); the whole pipeline freezes while stalled.
module vecmac_acc #(
    parameter int LANES = 4,
    parameter int DW    = 8,
    parameter int ACC_W = 32,
    parameter bit SAT   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*DW-1:0]   in_a,
    input  logic [LANES*DW-1:0]   in_b,
    input  logic                  in_last,
    input  logic                  in_signed,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_W-1:0]      out_acc,
    output logic                  out_sat
);
    // Product width (one extra bit so unsigned products stay non-negative as signed values).
    localparam int PW  = 2*DW + 1;
    // Lane-sum width with headroom for LANES additions.
    localparam int LSW = PW + $clog2(LANES);
    // Registered lane-sum width: wide enough for both the lane sum and the accumulator range.
    localparam int SW  = ((LSW > ACC_W) ? LSW : ACC_W) + 1;
    // Working width of the accumulate adder, so overflow is visible before clamping.
    localparam int XW  = SW + 1;

    // Per-beat control carried alongside the data through the pipeline.
    typedef struct packed {
        logic vld;
        logic first;
        logic last;
        logic sgn;
    } ctl_t;

    logic                 stall;
    logic                 accept;
    logic                 first_q;
    logic                 mode_q;
    logic                 eff_sgn;

    logic signed [PW-1:0] prod_c [LANES];
    logic signed [PW-1:0] s1_prod [LANES];
    ctl_t                 s1_ctl;

    logic signed [SW-1:0] lsum_c;
    logic signed [SW-1:0] s2_lsum;
    ctl_t                 s2_ctl;

    logic [ACC_W-1:0]     acc_q;
    logic                 sat_q;
    logic                 s3_vld;
    logic                 s3_last;

    logic signed [XW-1:0] acc_ext;
    logic signed [XW-1:0] base_x;
    logic signed [XW-1:0] sum_x;
    logic signed [XW-1:0] hi_x;
    logic signed [XW-1:0] lo_x;
    logic                 ovf;
    logic [ACC_W-1:0]     acc_nxt;
    logic                 sat_nxt;

    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;
    assign accept   = in_valid && in_ready;
    // The first beat of a transaction chooses the mode; later beats reuse the latched one.
    assign eff_sgn  = first_q ? in_signed : mode_q;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic signed [PW-1:0] ea;
        logic signed [PW-1:0] eb;
        assign ea = {{(DW+1){eff_sgn & in_a[k*DW+DW-1]}}, in_a[k*DW +: DW]};
        assign eb = {{(DW+1){eff_sgn & in_b[k*DW+DW-1]}}, in_b[k*DW +: DW]};
        // True product always fits in PW bits, so the truncated multiply is exact.
        assign prod_c[k] = ea * eb;
    end

    // Track transaction boundaries and the latched operand mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_q <= 1'b1;
            mode_q  <= 1'b0;
        end else if (accept) begin
            first_q <= in_last;
            mode_q  <= eff_sgn;
        end
    end

    // S1: register lane products and beat control.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_ctl <= '0;
            for (int k = 0; k < LANES; k++) s1_prod[k] <= '0;
        end else if (!stall) begin
            s1_ctl <= '{vld: accept, first: first_q, last: in_last, sgn: eff_sgn};
            for (int k = 0; k < LANES; k++) s1_prod[k] <= prod_c[k];
        end
    end

    // Sum the sign-extended lane products.
    always_comb begin
        lsum_c = '0;
        for (int k = 0; k < LANES; k++) begin
            lsum_c = lsum_c + {{(SW-PW){s1_prod[k][PW-1]}}, s1_prod[k]};
        end
    end

    // S2: register the lane sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_ctl  <= '0;
            s2_lsum <= '0;
        end else if (!stall) begin
            s2_ctl  <= s1_ctl;
            s2_lsum <= lsum_c;
        end
    end

    // Accumulate in a wider signed domain, then clamp or wrap back to ACC_W bits.
    always_comb begin
        acc_ext = {{(XW-ACC_W){s2_ctl.sgn & acc_q[ACC_W-1]}}, acc_q};
        base_x  = s2_ctl.first ? '0 : acc_ext;
        sum_x   = base_x + {s2_lsum[SW-1], s2_lsum};
        if (s2_ctl.sgn) begin
            hi_x = {{(XW-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
            lo_x = {{(XW-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};
        end else begin
            hi_x = {{(XW-ACC_W){1'b0}}, {ACC_W{1'b1}}};
            lo_x = '0;
        end
        ovf     = SAT && ((sum_x > hi_x) || (sum_x < lo_x));
        acc_nxt = sum_x[ACC_W-1:0];
        if (SAT && (sum_x > hi_x)) begin
            acc_nxt = hi_x[ACC_W-1:0];
        end else if (SAT && (sum_x < lo_x)) begin
            acc_nxt = lo_x[ACC_W-1:0];
        end
        sat_nxt = (s2_ctl.first ? 1'b0 : sat_q) | ovf;
    end

    // S3: update the accumulator and sticky saturation flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            sat_q   <= 1'b0;
            s3_vld  <= 1'b0;
            s3_last <= 1'b0;
        end else if (!stall) begin
            s3_vld  <= s2_ctl.vld;
            s3_last <= s2_ctl.vld && s2_ctl.last;
            if (s2_ctl.vld) begin
                acc_q <= acc_nxt;
                sat_q <= sat_nxt;
            end
        end
    end

    // Output register: load a finished transaction, drop valid after the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_acc   <= '0;
            out_sat   <= 1'b0;
        end else if (!stall && s3_vld && s3_last) begin
            out_valid <= 1'b1;
            out_acc   <= acc_q;
            out_sat   <= sat_q;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_vecmac_acc.sv
`timescale 1ns/1ps
module tb_vecmac_acc;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [31:0] in_a, in_b;
    logic        in_last, in_signed;

    // Instance a: default parameters. Instance s: 18-bit saturating accumulator.
    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_sat;
    logic [31:0] a_out_acc;
    logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_sat;
    logic [17:0] s_out_acc;

    logic        rnd_ready;
    int          errors = 0;
    int          checks = 0;
    logic [32:0] qa[$];
    logic [32:0] qs[$];
    logic [32:0] exp_a, exp_s;
    bit          m_first[2];
    bit          m_sgn[2];
    bit          m_sat[2];
    longint      m_acc[2];
    int          left;
    logic        sg;
    int          drain_n;

    vecmac_acc u_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .in_signed(in_signed),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_acc(a_out_acc), .out_sat(a_out_sat)
    );

    vecmac_acc #(.LANES(4), .DW(8), .ACC_W(18), .SAT(1'b1)) u_s (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .in_signed(in_signed),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_acc(s_out_acc), .out_sat(s_out_sat)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic longint lane_sum(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        longint r, x, y;
        r = 0;
        for (int k = 0; k < 4; k++) begin
            x = {{56{sgn & a[k*8+7]}}, a[k*8 +: 8]};
            y = {{56{sgn & b[k*8+7]}}, b[k*8 +: 8]};
            r += x * y;
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int w = 0; w < 2; w++) begin
            m_first[w] = 1'b1;
            m_sgn[w]   = 1'b0;
            m_sat[w]   = 1'b0;
            m_acc[w]   = 0;
        end
        qa.delete();
        qs.delete();
    endtask

    // Reference model: one accepted beat; pushes the expected result on a last beat.
    task automatic model_accept(input int w, input logic [31:0] a, input logic [31:0] b,
                                input logic last, input logic sgn);
        longint s, hi, lo;
        int aw;
        logic [63:0] t;
        aw = (w == 0) ? 32 : 18;
        if (m_first[w]) begin
            m_sgn[w] = sgn;
            m_acc[w] = 0;
            m_sat[w] = 1'b0;
        end
        s = m_acc[w] + lane_sum(a, b, m_sgn[w]);
        if (m_sgn[w]) begin
            hi = (longint'(1) << (aw - 1)) - 1;
            lo = -(longint'(1) << (aw - 1));
        end else begin
            hi = (longint'(1) << aw) - 1;
            lo = 0;
        end
        if (s > hi) begin
            s = hi;
            m_sat[w] = 1'b1;
        end else if (s < lo) begin
            s = lo;
            m_sat[w] = 1'b1;
        end
        m_acc[w]   = s;
        m_first[w] = last;
        if (last) begin
            t = s & ((longint'(1) << aw) - 1);
            if (w == 0) qa.push_back({m_sat[w], t[31:0]});
            else        qs.push_back({m_sat[w], t[31:0]});
        end
    endtask

    // Present one beat and hold it until accepted (bounded).
    task automatic beat(input int w, input logic [31:0] a, input logic [31:0] b,
                        input logic last, input logic sgn);
        int n;
        logic rdy;
        n = 0;
        in_a = a; in_b = b; in_last = last; in_signed = sgn;
        if (w == 0) a_in_valid = 1'b1; else s_in_valid = 1'b1;
        #1;
        rdy = (w == 0) ? a_in_ready : s_in_ready;
        while (!rdy && n < 500) begin
            @(posedge clk); #2;
            n++;
            rdy = (w == 0) ? a_in_ready : s_in_ready;
        end
        if (!rdy) chk("in_ready_timeout", 64'(rdy), 64'd1);
        else      model_accept(w, a, b, last, sgn);
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        s_in_valid = 1'b0;
    endtask

    // Wait (bounded) for the next cycle showing out_valid and compare against a constant.
    task automatic wait_out(input int w, input string tag, input logic [31:0] exp_acc, input logic exp_sat);
        int n;
        logic v;
        n = 0;
        do begin
            @(posedge clk); #2;
            n++;
            v = (w == 0) ? a_out_valid : s_out_valid;
        end while (!v && n < 50);
        chk({tag, "_vld"}, 64'(v), 64'd1);
        if (w == 0) chk(tag, 64'({a_out_sat, a_out_acc}), 64'({exp_sat, exp_acc}));
        else        chk(tag, 64'({s_out_sat, 14'b0, s_out_acc}), 64'({exp_sat, exp_acc}));
    endtask

    task automatic sync();
        @(posedge clk); #1;
    endtask

    // Scoreboard: every result handshake is compared in order with the model queue.
    always @(negedge clk) begin
        if (rst_n && a_out_valid && a_out_ready) begin
            if (qa.size() == 0) begin
                chk("a_spurious_result", 64'(a_out_valid), 64'd0);
            end else begin
                exp_a = qa.pop_front();
                chk("a_scoreboard", 64'({a_out_sat, a_out_acc}), 64'(exp_a));
            end
        end
        if (rst_n && s_out_valid && s_out_ready) begin
            if (qs.size() == 0) begin
                chk("s_spurious_result", 64'(s_out_valid), 64'd0);
            end else begin
                exp_s = qs.pop_front();
                chk("s_scoreboard", 64'({s_out_sat, 14'b0, s_out_acc}), 64'(exp_s));
            end
        end
    end

    // Random consumer backpressure, enabled only during the long random run.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (rnd_ready) a_out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        in_a = '0; in_b = '0; in_last = 1'b0; in_signed = 1'b0;
        a_in_valid = 1'b0; s_in_valid = 1'b0;
        a_out_ready = 1'b0; s_out_ready = 1'b1;
        rnd_ready = 1'b0;
        model_reset();
        #12;
        chk("rst_out_valid", 64'(a_out_valid), 64'd0);
        chk("rst_out_acc",   64'(a_out_acc),   64'd0);
        chk("rst_out_sat",   64'(a_out_sat),   64'd0);
        chk("rst_in_ready",  64'(a_in_ready),  64'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        sync();

        // Unsigned single beat of all-ones: 4 * 255 * 255, valid exactly 3 edges after acceptance.
        beat(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
        chk("t1_lat0", 64'(a_out_valid), 64'd0);
        repeat (2) begin
            @(posedge clk); #2;
            chk("t1_lat_early", 64'(a_out_valid), 64'd0);
        end
        @(posedge clk); #2;
        chk("t1_lat3", 64'(a_out_valid), 64'd1);
        chk("t1_acc",  64'(a_out_acc),   64'd260100);
        chk("t1_sat",  64'(a_out_sat),   64'd0);
        a_out_ready = 1'b1;
        sync();

        // Signed -128*127 per lane; then the same bits unsigned, 128*127 per lane.
        beat(0, 32'h8080_8080, 32'h7F7F_7F7F, 1'b1, 1'b1);
        wait_out(0, "t2_signed", 32'hFFFF_0200, 1'b0);
        sync();
        beat(0, 32'h8080_8080, 32'h7F7F_7F7F, 1'b1, 1'b0);
        wait_out(0, "t2_unsigned", 32'd65024, 1'b0);
        sync();

        // Three back-to-back beats then an immediate zero transaction.
        beat(0, 32'h0101_0101, 32'h0202_0202, 1'b0, 1'b0);
        beat(0, 32'h0101_0101, 32'h0202_0202, 1'b0, 1'b1);
        beat(0, 32'h0101_0101, 32'h0202_0202, 1'b1, 1'b1);
        beat(0, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0);
        wait_out(0, "t3_three_beat", 32'd24, 1'b0);
        wait_out(0, "t3_next_zero", 32'd0, 1'b0);
        sync();

        // Stall with a pending result while a long random stream waits behind it.
        a_out_ready = 1'b0;
        beat(0, 32'h0101_0101, 32'h0303_0303, 1'b1, 1'b0);
        wait_out(0, "t4_pending", 32'd12, 1'b0);
        left = 0;
        fork
            begin
                for (int i = 0; i < 4096; i++) begin
                    if (left == 0) begin
                        left = $urandom_range(1, 6);
                        sg = 1'($urandom_range(0, 1));
                        left--;
                        beat(0, $urandom, $urandom, (left == 0) || (i == 4095), sg);
                    end else begin
                        left--;
                        beat(0, $urandom, $urandom, (left == 0) || (i == 4095),
                             1'($urandom_range(0, 1)));
                    end
                end
            end
            begin
                repeat (10) begin
                    @(posedge clk); #3;
                    chk("t4_stall_in_ready", 64'(a_in_ready),  64'd0);
                    chk("t4_stall_valid",    64'(a_out_valid), 64'd1);
                    chk("t4_stall_acc",      64'(a_out_acc),   64'd12);
                end
                rnd_ready = 1'b1;
            end
        join
        rnd_ready = 1'b0;
        a_out_ready = 1'b1;
        drain_n = 0;
        while (qa.size() != 0 && drain_n < 300) begin
            @(posedge clk);
            drain_n++;
        end
        #1;
        chk("t4_drained", 64'(qa.size()), 64'd0);
        sync();

        // 18-bit saturating instance: unsigned and signed clamps, then the flag clears.
        beat(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        beat(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
        wait_out(1, "t5_unsigned_clamp", 32'd262143, 1'b1);
        sync();
        beat(1, 32'h8080_8080, 32'h8080_8080, 1'b0, 1'b1);
        beat(1, 32'h8080_8080, 32'h8080_8080, 1'b1, 1'b1);
        wait_out(1, "t5_signed_clamp", 32'd131071, 1'b1);
        sync();
        beat(1, 32'h0101_0101, 32'h0101_0101, 1'b1, 1'b0);
        wait_out(1, "t5_sat_cleared", 32'd4, 1'b0);
        sync();

        // Reset in the middle of a transaction discards the partial sum.
        beat(0, 32'h0102_0304, 32'h0506_0708, 1'b0, 1'b0);
        beat(0, 32'h0102_0304, 32'h0506_0708, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid",    64'(a_out_valid), 64'd0);
        chk("t6_rst_acc",      64'(a_out_acc),   64'd0);
        chk("t6_rst_in_ready", 64'(a_in_ready),  64'd1);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        sync();
        beat(0, 32'h0000_00FF, 32'h0000_00FF, 1'b1, 1'b0);
        wait_out(0, "t6_after_reset", 32'd65025, 1'b0);
        repeat (3) sync();
        chk("t6_queue_empty", 64'(qa.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
